// File: rtl/j_mac_pkg.sv
// j_mac_pkg: shared widths and types for the bit-serial MAC cell
package j_mac_pkg;
    localparam int W_BITS    = 8;
    localparam int WORD_BITS = 32;
    typedef logic [W_BITS-1:0] weight_t;
endpackage

// File: rtl/j_serial_adder.sv
// j_serial_adder: bit-serial full adder with registered carry and sum; carry reloads on init
module j_serial_adder (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic init,
    input  logic cin_init,
    input  logic a,
    input  logic b,
    output logic sum
);
    logic carry_q, carry_d, sum_q, sum_d, cin;
    always_comb begin
        cin = init ? cin_init : carry_q;
        {carry_d, sum_d} = en ? {1'b0, a} + {1'b0, b} + {1'b0, cin} : 2'b00;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            sum_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            sum_q   <= sum_d;
        end
    end
    assign sum = sum_q;
endmodule

// File: rtl/j_serial_mac.sv
// j_serial_mac: bit-serial result = data * w + acc (mod 2^32), signed weight held locally
module j_serial_mac
    import j_mac_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic accumulation,
    input  logic plus_one,
    input  logic clear_accu_control,
    input  logic dataflow_in,
    input  logic control1,
    input  logic update_w,
    input  logic mac_en,
    output logic result,
    output logic input_accu_adder
);
    weight_t           wreg_q, wreg_d;
    logic              neg_q, neg_d;
    logic [W_BITS:0]   p_q, p_d, s;
    logic              p1_q, p1_d, a1_q, a1_d, st1_q, st1_d, start;
    always_comb begin
        start  = plus_one | clear_accu_control;
        s      = (start ? '0 : p_q) + ((dataflow_in & ~update_w) ? {1'b0, wreg_q} : '0);
        wreg_d = update_w ? {dataflow_in, wreg_q[W_BITS-1:1]} : wreg_q;
        neg_d  = update_w ? ~control1 : neg_q;
        p_d    = mac_en ? s >> 1 : '0;
        p1_d   = mac_en & (s[0] ^ neg_q);
        a1_d   = mac_en & accumulation;
        st1_d  = mac_en & start;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wreg_q <= '0;
            neg_q  <= 1'b0;
            p_q    <= '0;
            p1_q   <= 1'b0;
            a1_q   <= 1'b0;
            st1_q  <= 1'b0;
        end else begin
            wreg_q <= wreg_d;
            neg_q  <= neg_d;
            p_q    <= p_d;
            p1_q   <= p1_d;
            a1_q   <= a1_d;
            st1_q  <= st1_d;
        end
    end
    j_serial_adder u_add (
        .clk      (clk),
        .reset    (reset),
        .en       (mac_en),
        .init     (st1_q),
        .cin_init (neg_q),
        .a        (a1_q),
        .b        (p1_q),
        .sum      (result)
    );
    assign input_accu_adder = p1_q;
endmodule

// File: tb/tb_j_serial_mac.sv
// tb_j_serial_mac: directed self-checking bench for the bit-serial MAC cell
module tb_j_serial_mac;
    logic clk = 1'b0, reset = 1'b1;
    logic accumulation = 1'b0, plus_one = 1'b0, clear_accu_control = 1'b0, dataflow_in = 1'b0;
    logic control1 = 1'b1, update_w = 1'b0, mac_en = 1'b0;
    logic result, input_accu_adder;
    int tests = 0, fails = 0;
    int wd[16], wa[16], n_words;

    j_serial_mac dut (
        .clk                (clk),
        .reset              (reset),
        .accumulation       (accumulation),
        .plus_one           (plus_one),
        .clear_accu_control (clear_accu_control),
        .dataflow_in        (dataflow_in),
        .control1           (control1),
        .update_w           (update_w),
        .mac_en             (mac_en),
        .result             (result),
        .input_accu_adder   (input_accu_adder)
    );

    always #5 clk = ~clk;

    task automatic load_w(input int w, input logic keep_en);
        logic [7:0] mag;
        mag = 8'(w < 0 ? -w : w);
        for (int i = 0; i < 8; i++) begin
            update_w = 1'b1;
            dataflow_in = mag[i];
            control1 = (w >= 0);
            mac_en = keep_en;
            plus_one = 1'b0;
            clear_accu_control = 1'b0;
            accumulation = 1'b0;
            @(posedge clk); #1;
        end
        update_w = 1'b0;
        dataflow_in = 1'b0;
    endtask

    // Streams n_words back-to-back words; result bit i of a word is read one edge after its product bit.
    task automatic run_words(input string name, input int w);
        logic [31:0] got, pgot, acc_b, exp, pexp, mag;
        logic [7:0] d_b;
        int j, i, k;
        mag = 32'(w < 0 ? -w : w);
        for (int t = 0; t <= 32 * n_words; t++) begin
            j = t / 32;
            i = t % 32;
            if (t < 32 * n_words) begin
                acc_b = 32'(wa[j]);
                d_b = 8'(wd[j]);
                plus_one = (i == 0);
                clear_accu_control = (i == 0);
                accumulation = acc_b[i];
                dataflow_in = (i < 8) ? d_b[i] : 1'b0;
            end else begin
                plus_one = 1'b1;
                clear_accu_control = 1'b1;
                accumulation = 1'b0;
                dataflow_in = 1'b0;
            end
            mac_en = 1'b1;
            update_w = 1'b0;
            @(posedge clk); #1;
            if (t < 32 * n_words) begin
                pgot[i] = input_accu_adder;
                if (i == 31) begin
                    pexp = 32'(wd[j]) * mag;
                    if (w < 0) pexp = ~pexp;
                    tests++;
                    if (pgot !== pexp) begin
                        fails++;
                        $display("FAIL %s product w=%0d d=%0d: got %h expected %h", name, w, wd[j], pgot, pexp);
                    end
                end
            end
            if (t >= 1) begin
                k = (t - 1) % 32;
                got[k] = result;
                if (k == 31) begin
                    exp = 32'(wd[(t - 1) / 32] * w + wa[(t - 1) / 32]);
                    tests++;
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL %s result w=%0d d=%0d acc=%0d: got %h expected %h",
                                 name, w, wd[(t - 1) / 32], wa[(t - 1) / 32], got, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests += 2;
        if (result !== 1'b0) begin fails++; $display("FAIL reset result: got %b expected 0", result); end
        if (input_accu_adder !== 1'b0) begin fails++; $display("FAIL reset iaa: got %b expected 0", input_accu_adder); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        n_words = 1;
        load_w(3, 1'b0);  wd[0] = 5; wa[0] = -2;  run_words("pos_w", 3);
        load_w(-10, 1'b0); wd[0] = 9; wa[0] = -10; run_words("neg_w", -10);
        load_w(0, 1'b0);  wd[0] = 7; wa[0] = -5;  run_words("zero_w", 0);
        load_w(9, 1'b0);  wd[0] = 0; wa[0] = 4;   run_words("zero_d", 9);
    endtask

    task automatic test_back_to_back();
        for (int w = -10; w <= 9; w++) begin
            load_w(w, 1'b1);
            for (int d = 0; d < 10; d++) begin
                wd[d] = d;
                wa[d] = ((w + 10 + 3 * d) % 20) - 10;
            end
            n_words = 10;
            run_words("sweep", w);
        end
    endtask

    task automatic test_reset_midword();
        logic [31:0] acc_b;
        load_w(2, 1'b0);
        acc_b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            plus_one = (i == 0);
            clear_accu_control = (i == 0);
            accumulation = acc_b[i];
            dataflow_in = (i < 2);
            mac_en = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        accumulation = 1'b1;
        dataflow_in = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            tests += 2;
            if (result !== 1'b0) begin fails++; $display("FAIL midreset result cyc%0d: got %b expected 0", c, result); end
            if (input_accu_adder !== 1'b0) begin fails++; $display("FAIL midreset iaa cyc%0d: got %b expected 0", c, input_accu_adder); end
        end
        reset = 1'b0;
        load_w(2, 1'b0);
        n_words = 1; wd[0] = 3; wa[0] = 1;
        run_words("after_reset", 2);
    endtask

    task automatic test_mac_en_gap();
        load_w(-1, 1'b0);
        n_words = 1; wd[0] = 2; wa[0] = 5;
        run_words("pre_gap", -1);
        mac_en = 1'b0;
        accumulation = 1'b1;
        dataflow_in = 1'b1;
        plus_one = 1'b0;
        clear_accu_control = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests += 2;
            if (result !== 1'b0) begin fails++; $display("FAIL gap result cyc%0d: got %b expected 0", c, result); end
            if (input_accu_adder !== 1'b0) begin fails++; $display("FAIL gap iaa cyc%0d: got %b expected 0", c, input_accu_adder); end
        end
        wd[0] = 1; wa[0] = 0;
        run_words("post_gap", -1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midword();
        test_mac_en_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
